doodle_physics: RTL and testbench
=================================

# doodle_physics

Per-frame motion engine for the Doodle character and a pool of up to NUM_SHOTS simultaneous cannon projectiles.
- Successor to the single-cannon jump logic: gravity, jump speed, screen geometry and projectile count are parameters, platform bounce is driven by an external contact input, and fire is edge-triggered with slot allocation.
- Sits between the keyboard/state-machine front end and the sprite renderer.
- Runs in the system clock domain, advancing once per frame strobe.

## Interface
- COORD_W, 10, coordinate width
- SCREEN_W / SCREEN_H, 640 / 480, visible area
- DOODLE_SIZE, 12, Doodle half-extent
- GRAVITY, 1, velocity increment per frame
- JUMP_VEL, 10, upward speed applied on bounce
- MAX_FALL, 8, terminal downward speed
- X_SPEED, 2, horizontal speed
- WRAP_MARGIN, 25, horizontal wrap margin
- NUM_SHOTS, 4, projectile slots
- SHOT_SPEED, 7, projectile upward speed per frame
- Clk  in  1  system clock. One clock only; all state changes on posedge Clk.
- Reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-Clk strobe per video frame; state advances only on this cycle
- mode  in  3  000 IDLE, 001 PLAY, 010 FREEZE; other codes are treated as FREEZE
- keycode  in  8  7/79 right, 4/80 left, 30 fire
- land  in  1  platform contact, sampled on frame_tick
- doodle_x, doodle_y  out  COORD_W  Doodle centre
- doodle_vy  out  8 signed  current vertical velocity
- shot_x, shot_y  out  NUM_SHOTS*COORD_W  flattened slot coordinates, slot 0 in the LSBs
- shot_active  out  NUM_SHOTS  slot-valid mask
- shot_drop  out  1  one-Clk pulse: fire request refused because all slots were busy

## Operation
- Derived limits:
  - X_MIN = WRAP_MARGIN+DOODLE_SIZE (37)
  - X_MAX = SCREEN_W-1-WRAP_MARGIN-DOODLE_SIZE (602)
  - Y_MAX = SCREEN_H-1-DOODLE_SIZE (467)
- IDLE: Doodle held at (SCREEN_W/2, SCREEN_H/2); vy=0; all shots cleared.
- FREEZE: all state held, including shots.
- PLAY, vertical motion, on each frame_tick:
  - grounded = (y==Y_MAX).
  - If grounded or (land and vy>=0): vy_n = -JUMP_VEL.
  - Otherwise: vy_n = min(vy+GRAVITY, MAX_FALL).
  - y_n = y + vy_n, computed signed in COORD_W+1 bits.
  - If y_n >= Y_MAX: y = Y_MAX.
  - If y_n < 0: y = 0 and vy = 0.
  - land while rising (vy<0) is ignored.
- PLAY, horizontal motion:
  - vx = +X_SPEED (keys 7/79), -X_SPEED (keys 4/80), 0 otherwise.
  - x_n = x + vx.
  - If x_n > X_MAX: x = X_MIN. If x_n < X_MIN: x = X_MAX. Otherwise x = x_n.
- Fire:
  - fire_edge = (keycode==30) on this tick and (keycode!=30) on the previous tick; the previous-key register updates every frame_tick.
  - On fire_edge, the lowest-index free slot loads the Doodle position from before this tick's update and becomes active.
  - If no slot is free, shot_drop pulses instead.
- Shots: each active slot does y -= SHOT_SPEED per tick.
  - Retire condition: y < WRAP_MARGIN+SHOT_SPEED, i.e. the next step would reach the margin.
  - On retire the slot clears active and zeroes its coordinates.
  - A slot retiring on a tick is not reallocatable until the next tick.

## Timing
- Reset values: doodle_x=320, doodle_y=240, doodle_vy=0, shot_x=shot_y=0, shot_active=0, shot_drop=0.
- All outputs are registered. Results of a frame_tick are visible on the Clk edge after it (latency 1 Clk).
- With frame_tick=0 the only change is shot_drop returning to 0.
- Reset asserted mid-frame clears all state immediately, including the previous-key register; no fire_edge is generated on the first tick after reset unless key 30 is pressed on that tick.
- A mode change takes effect on the same frame_tick it is sampled.

## Configuration
- DOODLE_SHOT_EN defined: projectile pool, fire detection and shot_drop are built.
- DOODLE_SHOT_EN undefined: the pool is not instantiated; shot_x, shot_y, shot_active and shot_drop are tied to 0; keycode 30 is ignored; Doodle behaviour is unchanged.

## Structure
- Package doodle_pkg:
  - mode enum (MODE_IDLE/MODE_PLAY/MODE_FREEZE)
  - keycode constants (KEY_LEFT, KEY_LEFT_ALT, KEY_RIGHT, KEY_RIGHT_ALT, KEY_FIRE)
  - COORD_W
- One sub-module, shot_slot: a single projectile register holding load/advance/retire and exposing free.
  - Instantiated NUM_SHOTS times through a generate loop.
  - Allocation is a priority encoder in the top level.

## Test plan
- Reset pulse mid-PLAY -> x=320, y=240, vy=0, shot_active=0000 on the next cycle.
- PLAY, no key, no land, from y=240, vy=0, three ticks -> vy 1,2,3 and y 241,243,246.
- vy=5, land=1 on a tick -> vy=-10, y decreases by 10. Then vy=-3, land=1 -> bounce ignored, vy=-2.
- x=601, key 7 -> x=37. Then key 4 from x=38 -> x=602.
- Key 30 held for 3 ticks -> only slot 0 active at the Doodle position, y-7 per tick.
  - Five separate presses with all slots busy -> slots 0-3 fill, fifth press pulses shot_drop once.
- mode=010 for 5 ticks -> all outputs constant. mode=000 -> Doodle at (320,240), shot_active=0000.

Source files
------------

// File: rtl/doodle_pkg.sv
// Shared types and constants for the Doodle motion engine.
// Mode codes, keycodes and the coordinate width live here.
package doodle_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [2:0] {
    MODE_IDLE   = 3'b000,
    MODE_PLAY   = 3'b001,
    MODE_FREEZE = 3'b010
  } mode_e;

  localparam logic [7:0] KEY_RIGHT     = 8'd7;
  localparam logic [7:0] KEY_RIGHT_ALT = 8'd79;
  localparam logic [7:0] KEY_LEFT      = 8'd4;
  localparam logic [7:0] KEY_LEFT_ALT  = 8'd80;
  localparam logic [7:0] KEY_FIRE      = 8'd30;

endpackage

// File: rtl/doodle_physics_shot_slot.sv
// One projectile slot: load from the Doodle, climb each frame,
// retire near the top margin.
module shot_slot
  import doodle_pkg::*;
#(
  parameter int SHOT_SPEED = 7,
  parameter int RETIRE_Y   = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               clear_i,
  input  logic               step_i,
  input  logic               load_i,
  input  logic [COORD_W-1:0] load_x_i,
  input  logic [COORD_W-1:0] load_y_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               active_o,
  output logic               free_o
);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               act_q, act_d;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    act_d = act_q;
    if (clear_i) begin
      x_d   = '0;
      y_d   = '0;
      act_d = 1'b0;
    end else if (load_i) begin
      x_d   = load_x_i;
      y_d   = load_y_i;
      act_d = 1'b1;
    end else if (step_i && act_q) begin
      if (y_q < COORD_W'(RETIRE_Y)) begin
        x_d   = '0;
        y_d   = '0;
        act_d = 1'b0;
      end else begin
        y_d = y_q - COORD_W'(SHOT_SPEED);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_q   <= '0;
      y_q   <= '0;
      act_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      act_q <= act_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign active_o = act_q;
  assign free_o   = ~act_q;

endmodule

// File: rtl/doodle_physics.sv
// Per-frame Doodle motion plus optional projectile pool.
// Define DOODLE_SHOT_EN to build the shots, fire edge and shot_drop.
module doodle_physics
  import doodle_pkg::*;
#(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int DOODLE_SIZE = 12,
  parameter int GRAVITY     = 1,
  parameter int JUMP_VEL    = 10,
  parameter int MAX_FALL    = 8,
  parameter int X_SPEED     = 2,
  parameter int WRAP_MARGIN = 25,
  parameter int NUM_SHOTS   = 4,
  parameter int SHOT_SPEED  = 7
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         frame_tick,
  input  logic [2:0]                   mode,
  input  logic [7:0]                   keycode,
  input  logic                         land,
  output logic [COORD_W-1:0]           doodle_x,
  output logic [COORD_W-1:0]           doodle_y,
  output logic signed [7:0]            doodle_vy,
  output logic [NUM_SHOTS*COORD_W-1:0] shot_x,
  output logic [NUM_SHOTS*COORD_W-1:0] shot_y,
  output logic [NUM_SHOTS-1:0]         shot_active,
  output logic                         shot_drop
);

  localparam int X_MIN = WRAP_MARGIN + DOODLE_SIZE;
  localparam int X_MAX = SCREEN_W - 1 - WRAP_MARGIN - DOODLE_SIZE;
  localparam int Y_MAX = SCREEN_H - 1 - DOODLE_SIZE;

  typedef logic signed [COORD_W:0] scoord_t;

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic signed [7:0]  vy_q, vy_d, vy_n;
  logic signed [8:0]  vy_inc;
  scoord_t            y_n, x_n, vx;
  logic               play, idle, bounce;
  logic               go_r, go_l;

  assign play = frame_tick && (mode == MODE_PLAY);
  assign idle = frame_tick && (mode == MODE_IDLE);
  assign go_r = (keycode == KEY_RIGHT) || (keycode == KEY_RIGHT_ALT);
  assign go_l = (keycode == KEY_LEFT) || (keycode == KEY_LEFT_ALT);

  always_comb begin
    bounce = (y_q == COORD_W'(Y_MAX)) || (land && !vy_q[7]);
    vy_inc = 9'(vy_q) + 9'(GRAVITY);
    if (bounce)
      vy_n = -8'(JUMP_VEL);
    else if (vy_inc > MAX_FALL)
      vy_n = 8'(MAX_FALL);
    else
      vy_n = vy_inc[7:0];
    y_n = $signed({1'b0, y_q}) + scoord_t'(vy_n);

    unique case (1'b1)
      go_r:    vx = scoord_t'(X_SPEED);
      go_l:    vx = -scoord_t'(X_SPEED);
      default: vx = '0;
    endcase
    x_n = $signed({1'b0, x_q}) + vx;

    x_d  = x_q;
    y_d  = y_q;
    vy_d = vy_q;
    if (idle) begin
      x_d  = COORD_W'(SCREEN_W / 2);
      y_d  = COORD_W'(SCREEN_H / 2);
      vy_d = '0;
    end else if (play) begin
      vy_d = vy_n;
      if (y_n >= Y_MAX) begin
        y_d = COORD_W'(Y_MAX);
      end else if (y_n < 0) begin
        y_d  = '0;
        vy_d = '0;
      end else begin
        y_d = y_n[COORD_W-1:0];
      end
      if (x_n > X_MAX)
        x_d = COORD_W'(X_MIN);
      else if (x_n < X_MIN)
        x_d = COORD_W'(X_MAX);
      else
        x_d = x_n[COORD_W-1:0];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_q  <= COORD_W'(SCREEN_W / 2);
      y_q  <= COORD_W'(SCREEN_H / 2);
      vy_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      vy_q <= vy_d;
    end
  end

  assign doodle_x  = x_q;
  assign doodle_y  = y_q;
  assign doodle_vy = vy_q;

`ifdef DOODLE_SHOT_EN
  localparam int RETIRE_Y = WRAP_MARGIN + SHOT_SPEED;

  logic [7:0]           key_q;
  logic                 fire_edge, found, drop_d, drop_q;
  logic [NUM_SHOTS-1:0] free, load;

  assign fire_edge = play && (keycode == KEY_FIRE) && (key_q != KEY_FIRE);

  // Lowest free slot wins; slots retiring this tick still read busy.
  always_comb begin
    load  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (fire_edge && free[i] && !found) begin
        load[i] = 1'b1;
        found   = 1'b1;
      end
    end
    drop_d = fire_edge && !found;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
      if (frame_tick)
        key_q <= keycode;
    end
  end

  for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
    shot_slot #(
      .SHOT_SPEED (SHOT_SPEED),
      .RETIRE_Y   (RETIRE_Y)
    ) u_slot (
      .Clk      (Clk),
      .Reset    (Reset),
      .clear_i  (idle),
      .step_i   (play),
      .load_i   (load[g]),
      .load_x_i (x_q),
      .load_y_i (y_q),
      .x_o      (shot_x[g*COORD_W +: COORD_W]),
      .y_o      (shot_y[g*COORD_W +: COORD_W]),
      .active_o (shot_active[g]),
      .free_o   (free[g])
    );
  end

  assign shot_drop = drop_q;
`else
  assign shot_x      = '0;
  assign shot_y      = '0;
  assign shot_active = '0;
  assign shot_drop   = 1'b0;
`endif

endmodule

// File: tb/tb_doodle_physics.sv
// Randomised check of doodle_physics against a frame-level model.
// Shot checks follow DOODLE_SHOT_EN as seen by this bench.
module tb_doodle_physics;
  import doodle_pkg::*;

  localparam int NS = 4;
  localparam int CW = COORD_W;
`ifdef DOODLE_SHOT_EN
  localparam bit SHOT_EN = 1'b1;
`else
  localparam bit SHOT_EN = 1'b0;
`endif

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic                 frame_tick;
  logic [2:0]           mode;
  logic [7:0]           keycode;
  logic                 land;
  logic [CW-1:0]        doodle_x, doodle_y;
  logic signed [7:0]    doodle_vy;
  logic [NS*CW-1:0]     shot_x, shot_y;
  logic [NS-1:0]        shot_active;
  logic                 shot_drop;

  doodle_physics dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .mode        (mode),
    .keycode     (keycode),
    .land        (land),
    .doodle_x    (doodle_x),
    .doodle_y    (doodle_y),
    .doodle_vy   (doodle_vy),
    .shot_x      (shot_x),
    .shot_y      (shot_y),
    .shot_active (shot_active),
    .shot_drop   (shot_drop)
  );

  always #5 Clk = ~Clk;

  int n_chk, n_bad;
  int mx, my, mvy, pkey, mdrop;
  int sx[NS], sy[NS];
  bit sa[NS];

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 320; my = 240; mvy = 0; pkey = 0; mdrop = 0;
    for (int i = 0; i < NS; i++) begin
      sx[i] = 0; sy[i] = 0; sa[i] = 0;
    end
  endtask

  task automatic model_tick(int md, int key, bit ld);
    int vyn, yn, xn, vx, ox, oy, slot;
    bit fe;
    bit fr[NS];
    ox = mx; oy = my;
    fe = SHOT_EN && (key == 30) && (pkey != 30);
    pkey = key;
    mdrop = 0;
    if (md == 0) begin
      model_reset();
      pkey = key;
    end else if (md == 1) begin
      if (my == 467 || (ld && mvy >= 0)) vyn = -10;
      else vyn = (mvy + 1 > 8) ? 8 : mvy + 1;
      yn = my + vyn;
      if (yn >= 467) begin my = 467; mvy = vyn; end
      else if (yn < 0) begin my = 0; mvy = 0; end
      else begin my = yn; mvy = vyn; end
      if (key == 7 || key == 79) vx = 2;
      else if (key == 4 || key == 80) vx = -2;
      else vx = 0;
      xn = mx + vx;
      if (xn > 602) mx = 37;
      else if (xn < 37) mx = 602;
      else mx = xn;
      for (int i = 0; i < NS; i++) fr[i] = !sa[i];
      for (int i = 0; i < NS; i++)
        if (sa[i]) begin
          if (sy[i] < 32) begin sa[i] = 0; sx[i] = 0; sy[i] = 0; end
          else sy[i] -= 7;
        end
      if (fe) begin
        slot = -1;
        for (int i = NS - 1; i >= 0; i--) if (fr[i]) slot = i;
        if (slot < 0) mdrop = 1;
        else begin sa[slot] = 1; sx[slot] = ox; sy[slot] = oy; end
      end
    end
  endtask

  task automatic check_all(string tag);
    int am;
    am = 0;
    chk({tag, "_x"}, int'(doodle_x), mx);
    chk({tag, "_y"}, int'(doodle_y), my);
    chk({tag, "_vy"}, int'(doodle_vy), mvy);
    for (int i = 0; i < NS; i++) begin
      if (sa[i]) am |= (1 << i);
      chk({tag, "_sx"}, int'(shot_x[i*CW +: CW]), sx[i]);
      chk({tag, "_sy"}, int'(shot_y[i*CW +: CW]), sy[i]);
    end
    chk({tag, "_act"}, int'(shot_active), am);
    chk({tag, "_drop"}, int'(shot_drop), mdrop);
  endtask

  task automatic tick(int md, int key, bit ld);
    @(negedge Clk);
    mode = md[2:0]; keycode = key[7:0]; land = ld; frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    model_tick(md, key, ld);
    check_all("tick");
    mode = 3'($urandom_range(0, 7));
    keycode = 8'($urandom_range(0, 255));
    land = 1'($urandom_range(0, 1));
    @(negedge Clk);
    chk("hold_drop", int'(shot_drop), 0);
    chk("hold_x", int'(doodle_x), mx);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    #1 Reset = 1'b0;
  endtask

  int keys[8] = '{0, 7, 79, 4, 80, 30, 30, 55};
  int drops, r, md;

  initial begin
    n_chk = 0; n_bad = 0;
    Reset = 1'b1; frame_tick = 1'b0; mode = 3'd0; keycode = 8'd0; land = 1'b0;
    repeat (2) @(negedge Clk);
    model_reset();
    check_all("init");
    Reset = 1'b0;

    tick(1, 7, 0); tick(1, 30, 0);
    do_reset();
    chk("rst_x", int'(doodle_x), 320);

    tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
    chk("fall_vy", int'(doodle_vy), 3);
    chk("fall_y", int'(doodle_y), 246);
    tick(1, 0, 0); tick(1, 0, 0);
    tick(1, 0, 1);
    chk("bounce_vy", int'(doodle_vy), -10);
    chk("bounce_y", int'(doodle_y), 245);
    repeat (7) tick(1, 0, 0);
    tick(1, 0, 1);
    chk("rise_vy", int'(doodle_vy), -2);

    for (int i = 0; i < 1000 && doodle_x != 10'd601; i++) tick(1, 7, 0);
    chk("reach_601", int'(doodle_x), 601);
    tick(1, 79, 0);
    chk("wrap_r", int'(doodle_x), 37);
    for (int i = 0; i < 1000 && doodle_x != 10'd38; i++) tick(1, 80, 0);
    tick(1, 4, 0);
    chk("wrap_l", int'(doodle_x), 602);

    tick(1, 30, 0); tick(1, 30, 0); tick(1, 30, 0);
    chk("fire_one", int'(shot_active), SHOT_EN ? 1 : 0);
    tick(0, 0, 0);
    drops = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      mode = 3'd1; keycode = 8'd30; land = 1'b0; frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
      model_tick(1, 30, 0);
      drops += int'(shot_drop);
      check_all("press");
      tick(1, 0, 0);
    end
    chk("drop_cnt", drops, SHOT_EN ? 1 : 0);
    chk("full", int'(shot_active), SHOT_EN ? 15 : 0);

    for (int i = 0; i < 5; i++) tick(2, $urandom_range(0, 255), 1'($urandom_range(0, 1)));
    tick(0, 30, 1);
    chk("idle_x", int'(doodle_x), 320);
    chk("idle_act", int'(shot_active), 0);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) md = 1;
      else if (r == 7) md = 0;
      else md = $urandom_range(2, 7);
      if ($urandom_range(0, 149) == 0) do_reset();
      tick(md, keys[$urandom_range(0, 7)], 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
